// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the scaled VGA scan-out engine:
//   - default 640x480@60 timing constants (used as parameter defaults)
//   - counter width used by the H/V timing counters
//   - {B,G,R} field positions inside a 24-bit palette word
//   - scan_flags_t, the per-pixel control bundle carried down the pipeline
//   - in_window(), the sync-window membership helper
// ---------------------------------------------------------------------------
package vga_pkg;

    // Width of the horizontal and vertical position counters.  Twelve bits
    // covers every total up to 4096, well beyond any VGA-class mode.
    localparam int CNT_W = 12;

    // 640x480@60 timing (pixel clock 25.175 MHz).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Palette word layout: {B[23:16], G[15:8], R[7:0]}.
    localparam int RGB_W = 24;
    localparam int B_MSB = 23;
    localparam int B_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int R_MSB = 7;
    localparam int R_LSB = 0;

    // Control bits that travel alongside each pixel.  hs/vs carry the
    // "sync asserted" meaning; pin polarity is applied only at the output.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic frame_start;
    } scan_flags_t;

    // True when pos lies in [first, first+len).  Used for both the
    // horizontal and vertical sync windows.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int unsigned      first,
                                       input int unsigned      len);
        int unsigned p;
        p = 32'(pos);
        return (p >= first) && (p < first + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running horizontal/vertical scan counters and the per-pixel control
// flags derived from them.  Everything produced here describes the pixel
// position of the current clock cycle ("stage 0"); downstream logic delays
// the flags to line them up with colour data.
//
// Ports
//   iVGA_CLK  in   pixel clock, rising edge
//   iRST_n    in   asynchronous active-low reset (scan restarts at h=v=0)
//   h_count   out  CNT_W  current column, 0 .. H_TOTAL-1
//   v_count   out  CNT_W  current line,   0 .. V_TOTAL-1
//   h_last    out  1      h_count is the final column of the line
//   v_last    out  1      v_count is the final line of the frame
//   flags     out  scan_flags_t  active / hs / vs / frame_start for (h,v)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             h_last,
    output logic             v_last,
    output scan_flags_t      flags
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);

    assign h_last = (h_count == H_LAST_C);
    assign v_last = (v_count == V_LAST_C);

    // Raster position.  The column wraps every line; the line advances only
    // on that wrap and itself wraps after the last line of the frame, so a
    // reset always restarts a complete frame from the top-left corner.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? '0 : v_count + CNT_W'(1);
        end else begin
            h_count <= h_count + CNT_W'(1);
        end
    end

    // Per-pixel flags for the current position.  Sync windows sit straight
    // after the front porch; VS spans whole lines because it depends on
    // v_count only.  Frame start marks the very first visible pixel.
    always_comb begin
        flags             = '0;
        flags.active      = (h_count < H_ACT_C) && (v_count < V_ACT_C);
        flags.hs          = in_window(h_count, unsigned'(H_ACTIVE + H_FP),
                                      unsigned'(H_SYNC));
        flags.vs          = in_window(v_count, unsigned'(V_ACTIVE + V_FP),
                                      unsigned'(V_SYNC));
        flags.frame_start = (h_count == '0) && (v_count == '0);
    end

endmodule

// File: rtl/vga_scaled_controller.sv
// ---------------------------------------------------------------------------
// vga_scaled_controller
//
// VGA scan-out engine: generates frame-buffer read addresses with integer
// pixel scaling, translates the returned palette indices through a writable
// 24-bit {B,G,R} palette, and drives sync/blank aligned with the colour.
//
// Pipeline (cycle t = the cycle an address is presented):
//   t            address out, stage-0 flags from the timing generator
//   t+MEM_LAT    index returns from frame memory
//   t+MEM_LAT+1  palette word registered
//   t+MEM_LAT+2  rgb, HS, VS, BLANK_n, FRAME_START registered at the pins
//
// Ports
//   iVGA_CLK      in   pixel clock, rising edge
//   iRST_n        in   asynchronous active-low reset
//   iPAL_WE       in   palette write strobe
//   iPAL_WADDR    in   IDX_W   palette write address
//   iPAL_WDATA    in   24      palette write data {B,G,R}
//   index         in   IDX_W   palette index from frame memory
//   address       out  ADDR_W  frame-buffer read address
//   oHS, oVS      out  sync outputs, asserted level HS_POL / VS_POL
//   oBLANK_n      out  1 = visible pixel on r/g/b_data
//   b/g/r_data    out  8 each, pixel colour (0 while blanked)
//   oFRAME_START  out  one-cycle pulse with the first visible pixel of a frame
// ---------------------------------------------------------------------------
module vga_scaled_controller
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   SCALE_LOG2 = 0,
    parameter int   IDX_W      = 8,
    parameter int   ADDR_W     = 19,
    parameter int   MEM_LAT    = 1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iPAL_WE,
    input  logic [IDX_W-1:0]  iPAL_WADDR,
    input  logic [RGB_W-1:0]  iPAL_WDATA,
    input  logic [IDX_W-1:0]  index,
    output logic [ADDR_W-1:0] address,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data,
    output logic              oFRAME_START
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCALE     = 1 << SCALE_LOG2;
    localparam int PAL_DEPTH = 1 << IDX_W;

    // Low-bit mask selecting the position inside one scaled pixel; a column
    // or line whose low bits are all ones is the last of its group.
    localparam logic [CNT_W-1:0]  S_MASK   = CNT_W'(SCALE - 1);
    localparam logic [CNT_W-1:0]  V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

    // Reject mode/scale/address combinations the incremental address
    // generator cannot represent.
    if (MEM_LAT < 1
        || (H_ACTIVE % SCALE) != 0
        || (V_ACTIVE % SCALE) != 0
        || H_TOTAL > (1 << CNT_W)
        || V_TOTAL > (1 << CNT_W)
        || longint'(H_ACTIVE >> SCALE_LOG2) * longint'(V_ACTIVE >> SCALE_LOG2)
           > (longint'(1) << ADDR_W)) begin : g_param_check
        $error("vga_scaled_controller: unsupported parameter combination");
    end

    // -----------------------------------------------------------------------
    // Timing
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_last;
    logic             v_last;
    scan_flags_t      flags;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .h_count  (h_count),
        .v_count  (v_count),
        .h_last   (h_last),
        .v_last   (v_last),
        .flags    (flags)
    );

    // -----------------------------------------------------------------------
    // Address generator
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] col_addr;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] held_addr;
    logic [ADDR_W-1:0] scan_addr;

    // col_addr tracks h>>S and row_base tracks (v>>S)*(H_ACTIVE>>S) without a
    // multiplier.  Both step after the last screen pixel of a scaled group so
    // the new value is ready on the first pixel of the next group.  The
    // overshoot past the final visible column/line is harmless: col_addr is
    // cleared at the end of every line and row_base at the end of the frame.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            col_addr <= '0;
            row_base <= '0;
        end else begin
            if (h_last) begin
                col_addr <= '0;
            end else if (flags.active && ((h_count & S_MASK) == S_MASK)) begin
                col_addr <= col_addr + ADDR_W'(1);
            end

            if (h_last) begin
                if (v_last) begin
                    row_base <= '0;
                end else if ((v_count < V_ACT_C) && ((v_count & S_MASK) == S_MASK)) begin
                    row_base <= row_base + ROW_STEP;
                end
            end
        end
    end

    assign scan_addr = row_base + col_addr;

    // Remember the last visible address so the frame memory sees a stable
    // address throughout the porches and sync periods.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            held_addr <= '0;
        end else if (flags.active) begin
            held_addr <= scan_addr;
        end
    end

    assign address = flags.active ? scan_addr : held_addr;

    // -----------------------------------------------------------------------
    // Palette RAM
    // -----------------------------------------------------------------------
    logic [RGB_W-1:0] pal_mem [PAL_DEPTH];
    logic [RGB_W-1:0] pal_q;

    // Write port.  Contents deliberately have no reset so the array maps
    // onto block RAM; software loads the palette after power-up.
    always_ff @(posedge iVGA_CLK) begin
        if (iPAL_WE) begin
            pal_mem[iPAL_WADDR] <= iPAL_WDATA;
        end
    end

    // Registered read port.  Reading the array before the write above lands
    // gives read-first behaviour: a same-cycle write to the entry being read
    // returns the old colour, the new one appears from the next read.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pal_q <= '0;
        end else begin
            pal_q <= pal_mem[index];
        end
    end

    // -----------------------------------------------------------------------
    // Flag alignment and output registers
    // -----------------------------------------------------------------------
    scan_flags_t flag_dly [MEM_LAT+1];
    scan_flags_t aligned;

    // Stage-0 flags ride a MEM_LAT+1 deep shift so that, together with the
    // output register, they lag the address by MEM_LAT+2 cycles -- the same
    // lag the colour data accumulates through memory and palette.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                flag_dly[i] <= '0;
            end
        end else begin
            flag_dly[0] <= flags;
            for (int i = 1; i <= MEM_LAT; i++) begin
                flag_dly[i] <= flag_dly[i-1];
            end
        end
    end

    assign aligned = flag_dly[MEM_LAT];

    // Pin registers.  Colour is forced to black whenever the aligned pixel
    // lies outside the visible area, whatever index memory returns there;
    // sync polarity is applied only here so the pipeline stays polarity-free.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS          <= ~HS_POL;
            oVS          <= ~VS_POL;
            oBLANK_n     <= 1'b0;
            oFRAME_START <= 1'b0;
            b_data       <= '0;
            g_data       <= '0;
            r_data       <= '0;
        end else begin
            oHS          <= aligned.hs ? HS_POL : ~HS_POL;
            oVS          <= aligned.vs ? VS_POL : ~VS_POL;
            oBLANK_n     <= aligned.active;
            oFRAME_START <= aligned.frame_start;
            b_data       <= aligned.active ? pal_q[B_MSB:B_LSB] : 8'h00;
            g_data       <= aligned.active ? pal_q[G_MSB:G_LSB] : 8'h00;
            r_data       <= aligned.active ? pal_q[R_MSB:R_LSB] : 8'h00;
        end
    end

endmodule
